crono_contador: RTL and testbench

CRONO_CONTADOR -- requirements
Module: crono_contador

---
 rtl/crono_contador.sv | 169 ++++++++++++++++
 tb/tb_crono_contador.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/crono_contador.sv
`default_nettype none
// ============================================================================
// Module   : crono_contador
// Brief    : BCD hh:mm:ss stopwatch with target match and alarm level.
//            Optional ring timeout enabled by macro CRONO_RING_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module crono_contador #(
   parameter int TICK_DIV  = 100000000,
   parameter int RING_SECS = 8
) (
   input  logic       clk,
   input  logic       Reset,
   input  logic       CronoActivo,
   input  logic       ProgramarCrono,
   input  logic [7:0] horasSal,
   input  logic [7:0] minutosSal,
   input  logic [7:0] segundosSal,
   output logic [7:0] horas,
   output logic [7:0] minutos,
   output logic [7:0] segundos,
   output logic       tick,
   output logic       FinalizoCrono,
   output logic       Ring,
   output logic [1:0] estado
);

   localparam int c_PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(TICK_DIV - 1);

   if (TICK_DIV < 2 || TICK_DIV > 134217728 || RING_SECS < 1 || RING_SECS > 255) begin : g_param_check
      $error("crono_contador: TICK_DIV or RING_SECS out of range");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10,
      S_DONE  = 2'b11
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_PRESC_W-1:0] r_presc;
   logic [7:0]           r_horas;
   logic [7:0]           r_minutos;
   logic [7:0]           r_segundos;
   logic                 r_fin;

   logic                 w_presc_wrap;
   logic                 w_presc_run;
   logic                 w_tick;
   logic                 w_match;
   logic                 w_ring_done;
   logic                 w_seg_wrap;
   logic                 w_min_wrap;
   logic [7:0]           w_seg_nxt;
   logic [7:0]           w_min_nxt;
   logic [7:0]           w_hor_nxt;
   logic                 w_tgt_valid;
   logic                 w_tgt_zero;

   function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic wrap);
      if (wrap)
         return 8'h00;
      if (v[3:0] >= 4'd9)
         return {v[7:4] + 4'd1, 4'h0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic bcd_ok(input logic [7:0] v);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

   // Next count value, with cascaded carries seconds -> minutes -> hours.
   always_comb begin
      w_seg_wrap = (r_segundos == 8'h59);
      w_min_wrap = (r_minutos == 8'h59);
      w_seg_nxt  = bcd_step(r_segundos, w_seg_wrap);
      w_min_nxt  = w_seg_wrap ? bcd_step(r_minutos, w_min_wrap) : r_minutos;
      w_hor_nxt  = (w_seg_wrap && w_min_wrap) ? bcd_step(r_horas, r_horas == 8'h23) : r_horas;
   end

   assign w_presc_wrap = (r_presc == c_PRESC_MAX);
   assign w_tick       = (r_state == S_RUN) && w_presc_wrap;
   assign w_tgt_valid  = bcd_ok(horasSal) && bcd_ok(minutosSal) && bcd_ok(segundosSal);
   assign w_tgt_zero   = ({horasSal, minutosSal, segundosSal} == 24'h000000);
   assign w_match      = w_tick && w_tgt_valid && !w_tgt_zero &&
                         ({w_hor_nxt, w_min_nxt, w_seg_nxt} == {horasSal, minutosSal, segundosSal});

`ifdef CRONO_RING_TIMEOUT_EN
   localparam logic [7:0] c_RING_LAST = 8'(RING_SECS - 1);
   logic [7:0] r_ring_cnt;

   always_ff @(posedge clk) begin
      if (Reset || ProgramarCrono || (r_state != S_DONE))
         r_ring_cnt <= 8'd0;
      else if (w_presc_wrap)
         r_ring_cnt <= r_ring_cnt + 8'd1;
   end

   assign w_ring_done = (r_state == S_DONE) && w_presc_wrap && (r_ring_cnt == c_RING_LAST);
   assign w_presc_run = (r_state == S_RUN) || (r_state == S_DONE);
`else
   assign w_ring_done = 1'b0;
   assign w_presc_run = (r_state == S_RUN);
`endif

   always_comb begin
      w_state_nxt = r_state;
      Ring        = 1'b0;
      case (r_state)
         S_IDLE:  if (CronoActivo) w_state_nxt = S_RUN;
         S_RUN: begin
            // A match wins over a simultaneous pause request.
            if (w_match)
               w_state_nxt = S_DONE;
            else if (!CronoActivo)
               w_state_nxt = S_PAUSE;
         end
         S_PAUSE: if (CronoActivo) w_state_nxt = S_RUN;
         S_DONE: begin
            Ring = 1'b1;
            if (w_ring_done)
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (ProgramarCrono)
         w_state_nxt = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         r_state    <= S_IDLE;
         r_presc    <= '0;
         r_horas    <= 8'h00;
         r_minutos  <= 8'h00;
         r_segundos <= 8'h00;
         r_fin      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_fin   <= w_match && !ProgramarCrono;
         if (ProgramarCrono) begin
            r_presc    <= '0;
            r_horas    <= 8'h00;
            r_minutos  <= 8'h00;
            r_segundos <= 8'h00;
         end else begin
            if (w_presc_run)
               r_presc <= w_presc_wrap ? '0 : r_presc + c_PRESC_W'(1);
            if (w_tick) begin
               r_horas    <= w_hor_nxt;
               r_minutos  <= w_min_nxt;
               r_segundos <= w_seg_nxt;
            end
         end
      end
   end

   assign horas         = r_horas;
   assign minutos       = r_minutos;
   assign segundos      = r_segundos;
   assign tick          = w_tick;
   assign FinalizoCrono = r_fin;
   assign estado        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_crono_contador.sv
`default_nettype none
// Bench for crono_contador at TICK_DIV=4, RING_SECS=3: count updates are
// scoreboarded by a monitor, state/alarm behaviour checked by directed vectors.
module tb_crono_contador;
   localparam int TICK_DIV  = 4;
   localparam int RING_SECS = 3;

   logic       clk = 1'b0;
   logic       Reset = 1'b1;
   logic       CronoActivo = 1'b0;
   logic       ProgramarCrono = 1'b0;
   logic [7:0] horasSal = 8'h00;
   logic [7:0] minutosSal = 8'h00;
   logic [7:0] segundosSal = 8'h00;
   logic [7:0] horas, minutos, segundos;
   logic       tick, FinalizoCrono, Ring;
   logic [1:0] estado;
   logic [23:0] w_cnt;

   int          n_checks = 0;
   int          n_fail = 0;
   int          m_secs = 0;
   logic [23:0] q_cnt[$];
   logic [23:0] q_fin[$];
   bit          p_tick = 1'b0;
   bit          p_fin = 1'b0;

   crono_contador #(.TICK_DIV(TICK_DIV), .RING_SECS(RING_SECS)) dut (
      .clk(clk), .Reset(Reset), .CronoActivo(CronoActivo), .ProgramarCrono(ProgramarCrono),
      .horasSal(horasSal), .minutosSal(minutosSal), .segundosSal(segundosSal),
      .horas(horas), .minutos(minutos), .segundos(segundos),
      .tick(tick), .FinalizoCrono(FinalizoCrono), .Ring(Ring), .estado(estado)
   );

   assign w_cnt = {horas, minutos, segundos};

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h required=%h", name, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [23:0] bcd_of(input int s);
      int h, m, x;
      h = s / 3600;
      m = (s / 60) % 60;
      x = s % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
   endfunction

   task automatic push_ticks(input int n);
      for (int k = 0; k < n; k++) begin
         m_secs = (m_secs + 1) % 86400;
         q_cnt.push_back(bcd_of(m_secs));
      end
   endtask

   task automatic set_target(input logic [23:0] t);
      {horasSal, minutosSal, segundosSal} = t;
   endtask

   // Monitor: a qualified tick means the count must change on the next cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (p_tick) begin
            if (q_cnt.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_update got=%h required=no update", w_cnt);
            end else begin
               chk("count_update", 32'(w_cnt), 32'(q_cnt.pop_front()));
            end
         end
         if (p_fin)
            chk("fin_width", 32'(FinalizoCrono), 32'(0));
         if (FinalizoCrono === 1'b1) begin
            if (q_fin.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_fin got=%h required=no pulse", w_cnt);
            end else begin
               chk("fin_count", 32'(w_cnt), 32'(q_fin.pop_front()));
               chk("fin_estado", 32'(estado), 32'(2'b11));
               chk("fin_ring", 32'(Ring), 32'(1));
            end
         end
         p_tick = (tick === 1'b1) && !Reset && !ProgramarCrono;
         p_fin  = (FinalizoCrono === 1'b1);
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog got=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
      $fatal(1);
   end

   initial begin
      cyc(2);
      Reset = 1'b0;
      chk("rst_count", 32'(w_cnt), 32'h0);
      chk("rst_estado", 32'(estado), 32'(0));
      chk("rst_ring", 32'(Ring), 32'(0));
      chk("rst_tick", 32'(tick), 32'(0));
      chk("rst_fin", 32'(FinalizoCrono), 32'(0));

      // Free run: tick every 4th cycle, BCD digits step 09 -> 10.
      CronoActivo = 1'b1;
      push_ticks(10);
      for (int i = 1; i <= 41; i++) begin
         cyc(1);
         chk("tick_period", 32'(tick), 32'(i % 4 == 0));
      end
      chk("run_count_10", 32'(w_cnt), 32'h000010);

      // Pause with the prescaler frozen at 2.
      cyc(1);
      CronoActivo = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         chk("pause_tick", 32'(tick), 32'(0));
      end
      chk("pause_estado", 32'(estado), 32'(2'b10));
      chk("pause_count", 32'(w_cnt), 32'h000010);
      CronoActivo = 1'b1;
      push_ticks(1);
      cyc(1);
      chk("resume_tick_early", 32'(tick), 32'(0));
      chk("resume_estado", 32'(estado), 32'(2'b01));
      cyc(1);
      chk("resume_tick", 32'(tick), 32'(1));

      // Run to 00:00:37, then reset mid-run.
      push_ticks(26);
      cyc(105);
      chk("count_37", 32'(w_cnt), 32'h000037);
      Reset = 1'b1;
      CronoActivo = 1'b0;
      cyc(1);
      Reset = 1'b0;
      m_secs = 0;
      chk("midrst_count", 32'(w_cnt), 32'h0);
      chk("midrst_estado", 32'(estado), 32'(0));
      cyc(3);
      chk("midrst_idle_hold", 32'(estado), 32'(0));

      // Target 00:01:05 reached after 65 ticks.
      set_target(24'h000105);
      CronoActivo = 1'b1;
      push_ticks(65);
      q_fin.push_back(24'h000105);
      cyc(261);
      chk("match_fin", 32'(FinalizoCrono), 32'(1));
      chk("match_estado", 32'(estado), 32'(2'b11));
      chk("match_ring", 32'(Ring), 32'(1));
      cyc(1);
      chk("match_fin_drop", 32'(FinalizoCrono), 32'(0));
      chk("done_estado", 32'(estado), 32'(2'b11));
`ifdef CRONO_RING_TIMEOUT_EN
      cyc(10);
      chk("ring_before_timeout", 32'(Ring), 32'(1));
      CronoActivo = 1'b0;
      cyc(1);
      chk("ring_timeout", 32'(Ring), 32'(0));
      chk("timeout_estado", 32'(estado), 32'(0));
      chk("timeout_count_kept", 32'(w_cnt), 32'h000105);
`else
      cyc(100);
      chk("ring_hold", 32'(Ring), 32'(1));
      chk("done_hold_estado", 32'(estado), 32'(2'b11));
      chk("done_hold_count", 32'(w_cnt), 32'h000105);
`endif
      ProgramarCrono = 1'b1;
      CronoActivo = 1'b0;
      cyc(1);
      ProgramarCrono = 1'b0;
      chk("prog_count", 32'(w_cnt), 32'h0);
      chk("prog_ring", 32'(Ring), 32'(0));
      chk("prog_estado", 32'(estado), 32'(0));

      // 23:59:59 wraps to 00:00:00; zero target never matches.
      set_target(24'h000000);
      force dut.r_horas = 8'h23;
      force dut.r_minutos = 8'h59;
      force dut.r_segundos = 8'h59;
      cyc(1);
      release dut.r_horas;
      release dut.r_minutos;
      release dut.r_segundos;
      cyc(1);
      chk("preload", 32'(w_cnt), 32'h235959);
      m_secs = 86399;
      CronoActivo = 1'b1;
      push_ticks(2);
      cyc(5);
      chk("wrap_count", 32'(w_cnt), 32'h000000);
      chk("wrap_fin", 32'(FinalizoCrono), 32'(0));
      // Pause request in the tick cycle: the tick still counts.
      cyc(3);
      chk("edge_tick", 32'(tick), 32'(1));
      CronoActivo = 1'b0;
      cyc(1);
      chk("edge_count", 32'(w_cnt), 32'h000001);
      chk("edge_estado", 32'(estado), 32'(2'b10));
      cyc(8);
      chk("edge_hold", 32'(w_cnt), 32'h000001);

      // Target changed in the very cycle of the matching increment.
      set_target(24'h000009);
      CronoActivo = 1'b1;
      push_ticks(2);
      q_fin.push_back(24'h000003);
      cyc(8);
      chk("late_tgt_tick", 32'(tick), 32'(1));
      set_target(24'h000003);
      cyc(1);
      chk("late_tgt_fin", 32'(FinalizoCrono), 32'(1));
      chk("late_tgt_estado", 32'(estado), 32'(2'b11));

      ProgramarCrono = 1'b1;
      CronoActivo = 1'b0;
      cyc(1);
      ProgramarCrono = 1'b0;
      cyc(2);
      chk("cnt_queue_drained", 32'(q_cnt.size()), 32'(0));
      chk("fin_queue_drained", 32'(q_fin.size()), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
